sndcmd_sched: RTL and testbench

- Sound-command scheduler between the main CPU's sound request (sndno/sndstart) and the 4 MHz sound Z80.
- Queues commands in a small FIFO and presents them one at a time on the command latch.
- Raises NMI per command and waits until the sound CPU has acknowledged the NMI and read the latch before presenting the next.
- Also generates the periodic sound-CPU IRQ; replaces the single-latch play-request logic so back-to-back requests are no longer lost.

---
 rtl/sndcmd_sched.sv | 122 ++++++++++++
 tb/tb_sndcmd_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sndcmd_sched.sv
// Sound-command scheduler: queues main-CPU sound requests and hands them to the
// sound Z80 one at a time (NMI + command latch), plus the periodic sound IRQ.
module sndcmd_sched #(
    parameter int DEPTH_LOG2 = 3,
    parameter int IRQ_PERIOD = 33334,
    parameter int GAP_TICKS  = 16,
    parameter int RD_TIMEOUT = 65535
) (
    input  logic                clk40M,
    input  logic                reset_n,
    input  logic                clk8M_en,
    input  logic [7:0]          sndno,
    input  logic                sndstart,
    output logic                cpu_irq,
    input  logic                cpu_irqa,
    output logic                cpu_nmi,
    input  logic                cpu_nmia,
    input  logic                com_rd,
    output logic [7:0]          comlatch,
    output logic [DEPTH_LOG2:0] fifo_count,
    output logic                overflow
);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int TMR_MAX = (RD_TIMEOUT > GAP_TICKS) ? RD_TIMEOUT : GAP_TICKS;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int IW      = $clog2(IRQ_PERIOD + 1);

    typedef enum logic [1:0] {S_IDLE, S_NMI, S_WAIT_RD, S_GAP} state_t;

    state_t                state, state_n;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  sndstart_q, com_rd_q;
    logic [TW-1:0]         tmr;
    logic [IW-1:0]         irq_cnt;
    logic                  push, push_ok, pop, rd_edge, full, empty;

    assign push    = clk8M_en && sndstart && !sndstart_q;
    assign rd_edge = clk8M_en && com_rd && !com_rd_q;
    assign full    = (fifo_count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (fifo_count == '0);
    assign pop     = clk8M_en && (state == S_IDLE) && !empty;
    // a pop on a full FIFO frees the slot the same-tick push lands in
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk40M) begin
        if (!reset_n) begin
            sndstart_q <= 1'b0;
            com_rd_q   <= 1'b0;
        end else if (clk8M_en) begin
            sndstart_q <= sndstart;
            com_rd_q   <= com_rd;
        end
    end

    always_ff @(posedge clk40M) begin
        if (push_ok) mem[wr_ptr] <= sndno;
    end

    always_ff @(posedge clk40M) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            comlatch   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                comlatch <= mem[rd_ptr];
            end
            if (push && !push_ok) overflow <= 1'b1;
            if (push_ok && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!push_ok && pop) fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk40M) begin
        if (!reset_n)      state <= S_IDLE;
        else if (clk8M_en) state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (!empty) state_n = S_NMI;
            S_NMI:     if (cpu_nmia) state_n = rd_edge ? S_GAP : S_WAIT_RD;
            S_WAIT_RD: if (rd_edge || tmr == TW'(RD_TIMEOUT - 1)) state_n = S_GAP;
            S_GAP:     if (tmr == TW'(GAP_TICKS - 1)) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_nmi = (state == S_NMI);
    end

    // shared by the read-wait and the inter-command gap; restarts on every state change
    always_ff @(posedge clk40M) begin
        if (!reset_n)                 tmr <= '0;
        else if (clk8M_en) begin
            if (state_n != state)     tmr <= '0;
            else if (state == S_WAIT_RD || state == S_GAP) tmr <= tmr + 1'b1;
        end
    end

    always_ff @(posedge clk40M) begin
        if (!reset_n) begin
            irq_cnt <= '0;
            cpu_irq <= 1'b0;
        end else if (clk8M_en) begin
            if (irq_cnt == IW'(IRQ_PERIOD - 1)) begin
                irq_cnt <= '0;
                cpu_irq <= 1'b1;
            end else begin
                irq_cnt <= irq_cnt + 1'b1;
                if (cpu_irqa) cpu_irq <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sndcmd_sched.sv
// Self-checking bench for sndcmd_sched: directed scenarios plus a randomized
// sound-CPU/host run checked against a transaction-level queue model.
module tb_sndcmd_sched;
    localparam int GAP = 16;
    localparam int TMO = 100;
    localparam int PER = 10;

    logic       clk40M = 1'b0, reset_n = 1'b0, clk8M_en = 1'b0;
    logic [7:0] sndno = 8'h00;
    logic       sndstart = 1'b0, cpu_irqa = 1'b0, cpu_nmia = 1'b0, com_rd = 1'b0;
    logic       cpu_irq, cpu_nmi, overflow;
    logic [7:0] comlatch;
    logic [3:0] fifo_count;
    int         total = 0, bad = 0, tcount = 0;

    always #5 clk40M = ~clk40M;

    sndcmd_sched #(.DEPTH_LOG2(3), .IRQ_PERIOD(PER), .GAP_TICKS(GAP), .RD_TIMEOUT(TMO)) dut (
        .clk40M(clk40M), .reset_n(reset_n), .clk8M_en(clk8M_en),
        .sndno(sndno), .sndstart(sndstart),
        .cpu_irq(cpu_irq), .cpu_irqa(cpu_irqa),
        .cpu_nmi(cpu_nmi), .cpu_nmia(cpu_nmia),
        .com_rd(com_rd), .comlatch(comlatch),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    // one 8 MHz tick: enable high across exactly one clk40M rising edge
    task automatic tick();
        @(negedge clk40M); clk8M_en = 1'b1;
        @(negedge clk40M); clk8M_en = 1'b0;
        tcount++;
    endtask

    task automatic do_reset();
        @(negedge clk40M);
        clk8M_en = 1'b0; reset_n = 1'b0;
        sndstart = 1'b0; cpu_nmia = 1'b0; com_rd = 1'b0; cpu_irqa = 1'b0;
        @(negedge clk40M);
        reset_n = 1'b1; tcount = 0;
    endtask

    task automatic push_code(input logic [7:0] code);
        sndno = code; sndstart = 1'b1; tick();
        sndstart = 1'b0; tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0d want=0", cpu_irq); end
        total++; if (cpu_nmi !== 1'b0) begin bad++; $display("FAIL reset_nmi got=%0d want=0", cpu_nmi); end
        total++; if (comlatch !== 8'h00) begin bad++; $display("FAIL reset_latch got=%0h want=0", comlatch); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0d want=0", overflow); end
    endtask

    task automatic test_single();
        int k;
        do_reset();
        sndno = 8'h42; sndstart = 1'b1; tick();
        total++; if (cpu_nmi !== 1'b0) begin bad++; $display("FAIL single_nmi_early got=%0d want=0", cpu_nmi); end
        total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL single_count1 got=%0d want=1", fifo_count); end
        tick();
        total++; if (cpu_nmi !== 1'b1) begin bad++; $display("FAIL single_nmi got=%0d want=1", cpu_nmi); end
        total++; if (comlatch !== 8'h42) begin bad++; $display("FAIL single_latch got=%0h want=42", comlatch); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL single_count0 got=%0d want=0", fifo_count); end
        sndstart = 1'b0; cpu_nmia = 1'b1; tick(); cpu_nmia = 1'b0;
        total++; if (cpu_nmi !== 1'b0) begin bad++; $display("FAIL single_nmi_ack got=%0d want=0", cpu_nmi); end
        com_rd = 1'b1; tick(); com_rd = 1'b0;
        // a push during the gap must wait out the gap before its NMI
        sndno = 8'h43; sndstart = 1'b1;
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            tick(); sndstart = 1'b0;
            if (i == GAP) begin
                total++; if (comlatch !== 8'h42) begin bad++; $display("FAIL single_hold got=%0h want=42", comlatch); end
            end
            if (cpu_nmi) begin k = i; break; end
        end
        total++; if (k != GAP + 1) begin bad++; $display("FAIL single_gap got=%0d want=%0d", k, GAP + 1); end
        total++; if (comlatch !== 8'h43) begin bad++; $display("FAIL single_latch2 got=%0h want=43", comlatch); end
    endtask

    task automatic test_burst();
        int peak, nrise, last_rd, phase, dly;
        bit prev, rd;
        logic [7:0] want;
        do_reset();
        peak = 0; nrise = 0; last_rd = -100; phase = 0; dly = 0; prev = 1'b0;
        for (int i = 0; i < 300; i++) begin
            sndstart = (i == 0 || i == 2 || i == 4);
            sndno = 8'(8'h10 + i / 2);
            cpu_nmia = 1'b0; com_rd = 1'b0;
            if (phase == 1) begin
                if (dly == 0) begin cpu_nmia = 1'b1; phase = 2; dly = 2; end else dly--;
            end else if (phase == 2) begin
                if (dly == 0) begin com_rd = 1'b1; phase = 0; end else dly--;
            end
            rd = com_rd;
            tick();
            if (rd) last_rd = tcount;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (cpu_nmi && !prev) begin
                nrise++; phase = 1; dly = 1;
                want = 8'(8'h10 + nrise - 1);
                total++; if (comlatch !== want) begin bad++; $display("FAIL burst_order got=%0h want=%0h", comlatch, want); end
                if (nrise > 1) begin
                    total++; if (tcount - last_rd < GAP) begin bad++; $display("FAIL burst_gap got=%0d want>=%0d", tcount - last_rd, GAP); end
                end
            end
            prev = cpu_nmi;
            if (nrise >= 3 && phase == 0 && tcount - last_rd > 40) break;
        end
        sndstart = 1'b0; cpu_nmia = 1'b0; com_rd = 1'b0;
        total++; if (nrise != 3) begin bad++; $display("FAIL burst_nmi_count got=%0d want=3", nrise); end
        total++; if (peak != 2) begin bad++; $display("FAIL burst_peak got=%0d want=2", peak); end
    endtask

    task automatic test_overflow();
        int k;
        logic [7:0] want;
        do_reset();
        for (int i = 0; i < 9; i++) push_code(8'(8'h20 + i));
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0d want=0", overflow); end
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ovf_full got=%0d want=8", fifo_count); end
        total++; if (comlatch !== 8'h20) begin bad++; $display("FAIL ovf_latch got=%0h want=20", comlatch); end
        push_code(8'h29);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0d want=1", overflow); end
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d want=8", fifo_count); end
        for (int j = 1; j <= 8; j++) begin
            cpu_nmia = 1'b1; com_rd = 1'b1; tick(); cpu_nmia = 1'b0; com_rd = 1'b0;
            k = -1;
            for (int i = 1; i <= 40; i++) begin tick(); if (cpu_nmi) begin k = i; break; end end
            want = 8'(8'h20 + j);
            total++; if (k < 0 || comlatch !== want) begin bad++; $display("FAIL ovf_drain got=%0h want=%0h wait=%0d", comlatch, want, k); end
        end
        cpu_nmia = 1'b1; com_rd = 1'b1; tick(); cpu_nmia = 1'b0; com_rd = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (cpu_nmi) k++; end
        total++; if (k != 0) begin bad++; $display("FAIL ovf_dropped got=%0d nmi ticks want=0", k); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0d want=1", overflow); end
    endtask

    task automatic test_full_pop_push();
        int k;
        logic [7:0] want;
        do_reset();
        for (int i = 0; i < 9; i++) push_code(8'(8'h30 + i));
        cpu_nmia = 1'b1; com_rd = 1'b1; tick(); cpu_nmia = 1'b0; com_rd = 1'b0;
        repeat (GAP) tick();
        // this tick is the pop tick of the full FIFO
        sndno = 8'h77; sndstart = 1'b1; tick(); sndstart = 1'b0;
        total++; if (cpu_nmi !== 1'b1) begin bad++; $display("FAIL fpp_nmi got=%0d want=1", cpu_nmi); end
        total++; if (comlatch !== 8'h31) begin bad++; $display("FAIL fpp_latch got=%0h want=31", comlatch); end
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL fpp_count got=%0d want=8", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%0d want=0", overflow); end
        for (int j = 2; j <= 9; j++) begin
            cpu_nmia = 1'b1; com_rd = 1'b1; tick(); cpu_nmia = 1'b0; com_rd = 1'b0;
            k = -1;
            for (int i = 1; i <= 40; i++) begin tick(); if (cpu_nmi) begin k = i; break; end end
            want = (j == 9) ? 8'h77 : 8'(8'h30 + j);
            total++; if (k < 0 || comlatch !== want) begin bad++; $display("FAIL fpp_order got=%0h want=%0h wait=%0d", comlatch, want, k); end
        end
    endtask

    task automatic test_timeout();
        int k;
        do_reset();
        push_code(8'h50); push_code(8'h51);
        cpu_nmia = 1'b1; tick(); cpu_nmia = 1'b0;
        k = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (i == TMO) begin
                total++; if (comlatch !== 8'h50) begin bad++; $display("FAIL tmo_hold got=%0h want=50", comlatch); end
            end
            if (cpu_nmi) begin k = i; break; end
        end
        total++; if (k != TMO + GAP + 1) begin bad++; $display("FAIL tmo_next got=%0d want=%0d", k, TMO + GAP + 1); end
        total++; if (comlatch !== 8'h51) begin bad++; $display("FAIL tmo_latch got=%0h want=51", comlatch); end
    endtask

    task automatic test_irq();
        bit want;
        do_reset();
        want = 1'b0;
        for (int t = 1; t <= 45; t++) begin
            cpu_irqa = (t == 13 || t == 20 || t == 40 || $urandom_range(0, 3) == 0);
            tick();
            if (tcount % PER == 0) want = 1'b1;
            else if (cpu_irqa) want = 1'b0;
            total++; if (cpu_irq !== want) begin bad++; $display("FAIL irq t=%0d got=%0d want=%0d", t, cpu_irq, want); end
        end
        cpu_irqa = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k;
        do_reset();
        for (int i = 0; i < 4; i++) push_code(8'(8'h60 + i));
        total++; if (fifo_count !== 4'd3 || cpu_nmi !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%0d/%0d want=3/1", fifo_count, cpu_nmi); end
        do_reset();
        total++; if (cpu_nmi !== 1'b0 || cpu_irq !== 1'b0) begin bad++; $display("FAIL rmid_irqnmi got=%0d/%0d want=0/0", cpu_nmi, cpu_irq); end
        total++; if (comlatch !== 8'h00 || fifo_count !== 4'd0 || overflow !== 1'b0) begin bad++; $display("FAIL rmid_state got=%0h/%0d/%0d want=0/0/0", comlatch, fifo_count, overflow); end
        k = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (cpu_nmi) k++; end
        total++; if (k != 0) begin bad++; $display("FAIL rmid_quiet got=%0d want=0", k); end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] want;
        int done, last_rd, phase, dly;
        bit prev, rd, pushed;
        do_reset();
        done = 0; last_rd = -100; phase = 0; dly = 0; prev = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done >= 25 && q.size() == 0 && phase == 0) break;
            cpu_nmia = 1'b0; com_rd = 1'b0;
            if (sndstart) sndstart = 1'b0;
            else if (done < 25 && $urandom_range(0, 5) == 0 && q.size() < 5) begin
                sndstart = 1'b1; sndno = 8'($urandom);
            end
            if (phase == 1) begin
                if (dly == 0) begin
                    cpu_nmia = 1'b1; dly = $urandom_range(0, 3);
                    if (dly == 0) begin com_rd = 1'b1; phase = 0; end else phase = 2;
                end else dly--;
            end else if (phase == 2) begin
                if (dly == 1) begin com_rd = 1'b1; phase = 0; end else dly--;
            end
            rd = com_rd; pushed = sndstart;
            tick();
            if (pushed) q.push_back(sndno);
            if (rd) begin last_rd = tcount; done++; end
            if (cpu_nmi && !prev) begin
                phase = 1; dly = $urandom_range(0, 4);
                want = (q.size() > 0) ? q.pop_front() : 8'hxx;
                total++; if (comlatch !== want) begin bad++; $display("FAIL rand_latch got=%0h want=%0h", comlatch, want); end
                total++; if (tcount - last_rd < GAP) begin bad++; $display("FAIL rand_gap got=%0d want>=%0d", tcount - last_rd, GAP); end
            end
            prev = cpu_nmi;
            total++; if (fifo_count !== 4'(q.size())) begin bad++; $display("FAIL rand_count got=%0d want=%0d", fifo_count, q.size()); end
        end
        sndstart = 1'b0; cpu_nmia = 1'b0; com_rd = 1'b0;
        total++; if (done < 25 || q.size() != 0) begin bad++; $display("FAIL rand_done got=%0d left=%0d want>=25/0", done, q.size()); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rand_ovf got=%0d want=0", overflow); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_pop_push();
        test_timeout();
        test_irq();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
